// File: rtl/timer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : timer_scheduler
//  Purpose  : Four-channel periodic timer. A shared prescaler produces a base
//             tick; each channel counts ticks up to its period and raises a
//             pending flag on expiry. A round-robin arbiter offers pending
//             expiries one at a time over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_scheduler #(
    parameter int PRESCALE = 50000,
    parameter int PW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_ch,
    input  logic [PW-1:0] cfg_period,
    input  logic          cfg_en,
    output logic          tick,
    output logic          evt_valid,
    output logic [1:0]    evt_id,
    input  logic          evt_ready,
    output logic [3:0]    pend,
    output logic [3:0]    ovf
);

    localparam int                c_PS_W     = $clog2(PRESCALE);
    localparam logic [c_PS_W-1:0] c_PS_MAX   = c_PS_W'(PRESCALE - 1);
    localparam logic [0:0]        c_ST_IDLE  = 1'b0;
    localparam logic [0:0]        c_ST_OFFER = 1'b1;

    logic [c_PS_W-1:0] r_ps;
    logic [0:0]        r_state;
    logic [1:0]        r_id;
    logic [1:0]        r_last;
    logic [1:0]        w_base;
    logic [1:0]        w_win;
    logic              w_found;
    logic              w_xfer;
    logic              w_take;
    logic [3:0]        w_clr;

    // Base prescaler: free-running 0..PRESCALE-1, tick marks the wrap cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ps <= '0;
        end else if (r_ps == c_PS_MAX) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + c_PS_W'(1);
        end
    end

    assign tick = (r_ps == c_PS_MAX);

    // Per-channel period counter with pending / overrun flags.
    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [PW-1:0] r_period;
        logic [PW-1:0] r_cnt;
        logic          r_en;
        logic          r_pend;
        logic          r_ovf;
        logic          w_hit;
        logic          w_run;
        logic          w_exp;

        // A configuration write to this channel overrides any tick activity.
        assign w_hit = cfg_we && (cfg_ch == 2'(g));
        assign w_run = tick && r_en && (r_period != '0);
        assign w_exp = w_run && (r_cnt == r_period - PW'(1)) && !w_hit;

        // Counter and configuration registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_period <= '0;
                r_en     <= 1'b0;
                r_cnt    <= '0;
            end else if (w_hit) begin
                r_period <= cfg_period;
                r_en     <= cfg_en;
                r_cnt    <= '0;
            end else if (w_run) begin
                r_cnt <= (r_cnt == r_period - PW'(1)) ? '0 : r_cnt + PW'(1);
            end
        end

        // Pending/overrun: an expiry racing the arbiter's clear wins without
        // counting as an overrun, since the earlier event is being consumed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pend <= 1'b0;
                r_ovf  <= 1'b0;
            end else if (w_hit) begin
                r_pend <= 1'b0;
                r_ovf  <= 1'b0;
            end else if (w_exp) begin
                r_pend <= 1'b1;
                if (r_pend && !w_clr[g]) begin
                    r_ovf <= 1'b1;
                end
            end else if (w_clr[g]) begin
                r_pend <= 1'b0;
            end
        end

        assign pend[g] = r_pend;
        assign ovf[g]  = r_ovf;
    end

    assign w_xfer = (r_state == c_ST_OFFER) && evt_ready;
    assign w_take = (pend != 4'b0000) && ((r_state == c_ST_IDLE) || evt_ready);
    assign w_base = w_xfer ? r_id : r_last;

    // Round-robin search starting one past the most recent grant.
    always_comb begin
        logic [1:0] v_cand;
        v_cand  = 2'd0;
        w_win   = 2'd0;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            v_cand = w_base + 2'(k);
            if (!w_found && pend[v_cand]) begin
                w_found = 1'b1;
                w_win   = v_cand;
            end
        end
    end

    assign w_clr = w_take ? (4'b0001 << w_win) : 4'b0000;

    // Arbiter: offer holds until accepted; a transfer chains straight into
    // the next winner so consecutive events leave no idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_id    <= 2'd0;
            r_last  <= 2'd3;
        end else begin
            if (w_xfer) begin
                r_last <= r_id;
            end
            if (w_take) begin
                r_state <= c_ST_OFFER;
                r_id    <= w_win;
            end else if (w_xfer) begin
                r_state <= c_ST_IDLE;
            end
        end
    end

    assign evt_valid = (r_state == c_ST_OFFER);
    assign evt_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_timer_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_timer_scheduler
//  Purpose  : Self-checking bench for timer_scheduler (PRESCALE=4) with a
//             behavioural reference model stepped once per clock.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_timer_scheduler;

    localparam int PRESCALE = 4;
    localparam int PW       = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_ch = 2'd0;
    logic [PW-1:0] cfg_period = '0;
    logic          cfg_en = 1'b0;
    logic          evt_ready = 1'b0;
    logic          tick;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic [3:0]    pend;
    logic [3:0]    ovf;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int       m_presc;
    int       m_cnt [4];
    int       m_per [4];
    bit       m_en  [4];
    bit [3:0] m_pend;
    bit [3:0] m_ovf;
    bit       m_valid;
    int       m_id;
    int       m_last;

    timer_scheduler #(.PRESCALE(PRESCALE), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .tick       (tick),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .pend       (pend),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_presc = 0;
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            m_per[c] = 0;
            m_en[c]  = 1'b0;
        end
        m_pend  = 4'b0;
        m_ovf   = 4'b0;
        m_valid = 1'b0;
        m_id    = 0;
        m_last  = 3;
    endfunction

    // One clock of behaviour, from the inputs presented before the edge.
    function automatic void model_update();
        bit       t;
        bit [3:0] ex;
        bit       xfer;
        bit       take;
        int       base;
        int       w;
        t = (m_presc == PRESCALE - 1);
        for (int c = 0; c < 4; c++) begin
            ex[c] = t && m_en[c] && (m_per[c] != 0) && (m_cnt[c] == m_per[c] - 1)
                    && !(cfg_we && (int'(cfg_ch) == c));
        end
        for (int c = 0; c < 4; c++) begin
            if (cfg_we && (int'(cfg_ch) == c)) begin
                m_cnt[c] = 0;
                m_per[c] = int'(cfg_period);
                m_en[c]  = cfg_en;
            end else if (t && m_en[c] && (m_per[c] != 0)) begin
                m_cnt[c] = (m_cnt[c] + 1) % m_per[c];
            end
        end
        xfer = m_valid && evt_ready;
        take = (m_pend != 4'b0) && (!m_valid || evt_ready);
        base = xfer ? m_id : m_last;
        w = -1;
        if (take) begin
            for (int k = 1; k <= 4; k++) begin
                if (w < 0 && m_pend[(base + k) % 4]) w = (base + k) % 4;
            end
        end
        if (xfer) m_last = m_id;
        if (take) begin
            m_valid = 1'b1;
            m_id    = w;
        end else if (xfer) begin
            m_valid = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            if (cfg_we && (int'(cfg_ch) == c)) begin
                m_pend[c] = 1'b0;
                m_ovf[c]  = 1'b0;
            end else if (ex[c]) begin
                if (m_pend[c] && (w != c)) m_ovf[c] = 1'b1;
                m_pend[c] = 1'b1;
            end else if (w == c) begin
                m_pend[c] = 1'b0;
            end
        end
        m_presc = (m_presc + 1) % PRESCALE;
    endfunction

    // Expected {tick, evt_valid, evt_id, pend, ovf}
    function automatic logic [11:0] exp_vec();
        logic [1:0] id2;
        id2 = m_id[1:0];
        return {(m_presc == PRESCALE - 1), m_valid, id2, m_pend, m_ovf};
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        cfg_we    = 1'b0;
        evt_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input int per, input logic en);
        cfg_we     = 1'b1;
        cfg_ch     = ch;
        cfg_period = PW'(per);
        cfg_en     = en;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_we = 1'b1;
        evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({tick, evt_valid, evt_id, pend, ovf} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", {tick, evt_valid, evt_id, pend, ovf}, 12'h000);
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_tick();
        apply_reset();
        for (int k = 1; k <= 16; k++) begin
            n_tests++;
            if (tick !== ((k % 4) == 0)) begin
                n_fail++;
                $display("FAIL tick_period: cycle %0d got %b expected %b", k, tick, ((k % 4) == 0));
            end
            step();
        end
    endtask

    task automatic test_single_channel();
        int n_ticks = 0;
        int last_third = -100;
        int n_events = 0;
        bit prev_valid = 1'b0;
        apply_reset();
        cfg_write(2'd1, 3, 1'b1);
        evt_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (tick) begin
                n_ticks++;
                if (n_ticks % 3 == 0) last_third = cyc;
            end
            if (evt_valid && !prev_valid) begin
                n_events++;
                n_tests++;
                if ((cyc - last_third) != 2 || evt_id !== 2'd1) begin
                    n_fail++;
                    $display("FAIL single_latency: cycle %0d delay %0d id %0d expected delay 2 id 1",
                             cyc, cyc - last_third, evt_id);
                end
            end
            n_tests++;
            if ({tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
                n_fail++;
                $display("FAIL single_model: cycle %0d got %h expected %h", cyc, {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
            end
            prev_valid = evt_valid;
            step();
        end
        // Expiries on ticks 3,6,9,12 land at cycles 12,24,36,48 of the window.
        n_tests++;
        if (n_events != 4) begin
            n_fail++;
            $display("FAIL single_count: got %0d events expected 4", n_events);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] prev_id;
        apply_reset();
        for (int c = 0; c < 4; c++) cfg_write(2'(c), 1, 1'b1);
        evt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if ({tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
                n_fail++;
                $display("FAIL rr_model: got %h expected %h", {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
            end
            step();
        end
        prev_id = evt_id;
        step();
        for (int i = 0; i < 32; i++) begin
            n_tests++;
            if (evt_valid !== 1'b1 || evt_id !== prev_id + 2'd1 || ovf !== 4'b0) begin
                n_fail++;
                $display("FAIL rr_order: valid %b id %0d ovf %b expected valid 1 id %0d ovf 0",
                         evt_valid, evt_id, ovf, prev_id + 2'd1);
            end
            prev_id = evt_id;
            step();
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        evt_ready = 1'b0;
        cfg_write(2'd2, 1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            n_tests++;
            if ({tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
                n_fail++;
                $display("FAIL bp_model: got %h expected %h", {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
            end
            step();
        end
        n_tests++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pend[2] !== 1'b1 || ovf[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_overrun: valid %b id %0d pend2 %b ovf2 %b expected 1 2 1 1", evt_valid, evt_id, pend[2], ovf[2]);
        end
        cfg_write(2'd2, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pend[2] !== 1'b0 || ovf[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_cfg_clear: valid %b id %0d pend2 %b ovf2 %b expected 1 2 0 0", evt_valid, evt_id, pend[2], ovf[2]);
            end
            step();
        end
        evt_ready = 1'b1;
        step();
        n_tests++;
        if (evt_valid !== 1'b0 || {tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
            n_fail++;
            $display("FAIL bp_accept: got %h expected %h", {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
        end
    endtask

    task automatic test_cfg_priority();
        bit found = 1'b0;
        apply_reset();
        evt_ready = 1'b1;
        cfg_write(2'd0, 2, 1'b1);
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_presc == PRESCALE - 1 && m_cnt[0] == 1) found = 1'b1;
            else step();
        end
        n_tests++;
        if (!found || tick !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_setup: found %b tick %b expected 1 1", found, tick);
        end
        cfg_write(2'd0, 2, 1'b1);
        // Counter restarts at 0: expiry on the second following tick, pend at +9.
        for (int j = 1; j <= 11; j++) begin
            n_tests++;
            if (pend[0] !== (j == 9) || {tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
                n_fail++;
                $display("FAIL prio_restart: cycle +%0d pend0 %b expected %b vec %h model %h",
                         j, pend[0], (j == 9), {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
            end
            step();
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            cfg_we     = ($urandom_range(0, 7) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = PW'($urandom_range(0, 3));
            cfg_en     = ($urandom_range(0, 3) != 0);
            evt_ready  = ($urandom_range(0, 2) != 0);
            step();
            n_tests++;
            if ({tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_model: iter %0d got %h expected %h", i, {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
            end
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        evt_ready = 1'b0;
        cfg_write(2'd0, 1, 1'b1);
        cfg_write(2'd3, 1, 1'b1);
        repeat (12) step();
        n_tests++;
        if (evt_valid !== 1'b1 || ovf === 4'b0 || {tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
            n_fail++;
            $display("FAIL async_setup: got %h expected %h", {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (evt_valid !== 1'b0 || pend !== 4'b0 || ovf !== 4'b0 || evt_id !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid %b pend %b ovf %b id %0d expected all 0", evt_valid, pend, ovf, evt_id);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            n_tests++;
            if ({tick, evt_valid, evt_id, pend, ovf} !== exp_vec()) begin
                n_fail++;
                $display("FAIL async_release: cycle %0d got %h expected %h", k, {tick, evt_valid, evt_id, pend, ovf}, exp_vec());
            end
            step();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tick();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_cfg_priority();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
